// File: rtl/copy_packet_to_mem_rb.sv
// RX frame store: writes MAC bytes into a circular RAM, queues {base,len} per good frame,
// and discards bad frames by rolling the write pointer back to the last commit point.
module copy_packet_to_mem_rb #(
  parameter int pDATA_W  = 8,
  parameter int pADDR_W  = 11,
  parameter int pLEN_W   = 14,
  parameter int pDESC_W  = 4,
  parameter int pMIN_LEN = 64,
  parameter int pMAX_LEN = 1518
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               idv,
  input  logic [pDATA_W-1:0] irx_d,
  input  logic               irx_er,
  input  logic [pLEN_W-1:0]  ir_addr,
  input  logic               irelease,
  output logic [pDATA_W-1:0] or_data,
  output logic [pLEN_W-1:0]  olen_pac,
  output logic               oempty,
  output logic               ofull,
  output logic               odrop,
  output logic [15:0]        odrop_cnt
);

  localparam int DEPTH = 1 << pADDR_W;
  localparam int NDESC = 1 << pDESC_W;

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

  state_t state, state_nxt;

  logic [pDATA_W-1:0] mem       [DEPTH];
  logic [pADDR_W-1:0] desc_base [NDESC];
  logic [pLEN_W-1:0]  desc_len  [NDESC];

  logic [pADDR_W-1:0] cptr, head_base, wr_addr;
  logic [pLEN_W-1:0]  cnt;
  logic [pADDR_W:0]   occ;
  logic [pDESC_W-1:0] dwp, drp;
  logic [pDESC_W:0]   dcnt, dcnt_nxt;
  logic               wr_en, start, grow, commit, rollback, rel, no_space;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge iclk) begin
    if (i_rst) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    start     = 1'b0;
    grow      = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    wr_addr   = (state == IDLE) ? cptr : cptr + pADDR_W'(cnt);
    rel       = irelease && !oempty && (dcnt != '0);
    no_space  = (32'(occ) + 32'(cnt)) >= 32'(DEPTH);
    case (state)
      SYNC: if (!idv) state_nxt = IDLE;
      IDLE: begin
        if (idv) begin
          // A completely full RAM cannot even take word 0 without clobbering the head frame.
          if (irx_er || (32'(occ) >= 32'(DEPTH))) begin
            state_nxt = DROP;
          end else begin
            wr_en     = 1'b1;
            start     = 1'b1;
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (idv) begin
          if (irx_er || (cnt == pLEN_W'(pMAX_LEN)) || no_space) begin
            state_nxt = DROP;
          end else begin
            wr_en = 1'b1;
            grow  = 1'b1;
          end
        end else begin
          if ((cnt >= pLEN_W'(pMIN_LEN)) && !ofull) commit = 1'b1;
          else                                      rollback = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!idv) begin
          rollback  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
    if (i_rst) wr_en = 1'b0;

    dcnt_nxt = dcnt;
    if (commit && !rel)      dcnt_nxt = dcnt + 1'b1;
    else if (rel && !commit) dcnt_nxt = dcnt - 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_addr] <= irx_d;
    if (commit) begin
      desc_base[dwp] <= cptr;
      desc_len[dwp]  <= cnt;
    end
  end

  always_ff @(posedge iclk) begin
    if (i_rst) begin
      cptr      <= '0;
      cnt       <= '0;
      occ       <= '0;
      dwp       <= '0;
      drp       <= '0;
      dcnt      <= '0;
      oempty    <= 1'b1;
      ofull     <= 1'b0;
      odrop     <= 1'b0;
      odrop_cnt <= '0;
      olen_pac  <= '0;
      head_base <= '0;
      or_data   <= '0;
    end else begin
      odrop <= rollback;
      if (rollback) odrop_cnt <= sat_inc(odrop_cnt);

      if (start)     cnt <= pLEN_W'(1);
      else if (grow) cnt <= cnt + pLEN_W'(1);

      if (commit) begin
        cptr <= cptr + pADDR_W'(cnt);
        dwp  <= dwp + 1'b1;
      end
      if (rel) drp <= drp + 1'b1;

      occ <= occ + (commit ? (pADDR_W+1)'(cnt) : '0)
                 - (rel ? (pADDR_W+1)'(desc_len[drp]) : '0);
      dcnt <= dcnt_nxt;

      // Head status lags the descriptor FIFO by one cycle; the release path above
      // reads the FIFO directly so back-to-back releases stay exact.
      ofull     <= (dcnt_nxt == (pDESC_W+1)'(NDESC));
      oempty    <= (dcnt == '0);
      olen_pac  <= desc_len[drp];
      head_base <= desc_base[drp];
      or_data   <= mem[head_base + pADDR_W'(ir_addr)];
    end
  end

endmodule
